phase_sequencer: RTL and testbench

Parametrised successor to the fixed 16-bit ring sequencer. Generates a one-hot machine-cycle phase vector of configurable length, with a binary phase index. Adds free-run, single-step, hold, reverse direction, phase load and drain-to-phase-0 stop. Drives the per-phase strobes of the dekatron CPU core: fetch, decode, counter up/down and memory.

---
 rtl/phase_sequencer.sv | 71 +++++++
 tb/tb_phase_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot machine-cycle phase generator with run/step/hold, reverse, load and drain-to-zero stop.
module phase_sequencer #(
    parameter int PHASES = 16,
    parameter int START_PHASE = 0,
    localparam int IDXW = $clog2(PHASES)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic              Step,
    input  logic              Hold,
    input  logic              Dir,
    input  logic              Load,
    input  logic [IDXW-1:0]   LoadPhase,
    output logic [PHASES-1:0] Out,
    output logic [IDXW-1:0]   Phase,
    output logic              CycleDone,
    output logic              Busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [IDXW-1:0] LAST = IDXW'(PHASES - 1);
    localparam logic [IDXW-1:0] START = IDXW'(START_PHASE);
    state_t state, stateNext;
    logic stepQ, stepEdge, loadOk, adv, wrap;
    logic [IDXW-1:0] stepPhase, phaseNext;
    assign stepEdge = Step && !stepQ;
    assign loadOk = Load && (int'(LoadPhase) < PHASES);
    assign wrap = Dir ? (Phase == '0) : (Phase == LAST);
    assign stepPhase = wrap ? (Dir ? LAST : '0) : (Dir ? Phase - IDXW'(1) : Phase + IDXW'(1));
    assign phaseNext = loadOk ? LoadPhase : (adv ? stepPhase : Phase);
    always_comb begin
        stateNext = state;
        adv = 1'b0;
        if (loadOk) begin
            stateNext = (state == DRAIN && LoadPhase == '0) ? IDLE : state;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = Run ? RUN : IDLE;
                    adv = !Run && stepEdge && !Hold;
                end
                RUN: begin
                    // stopping exactly on phase 0 needs no drain and no advance
                    adv = !Hold && (Run || Phase != '0);
                    stateNext = Run ? RUN : (Phase == '0 ? IDLE : DRAIN);
                end
                default: begin
                    adv = !Hold;
                    stateNext = Run ? RUN : ((adv && stepPhase == '0) ? IDLE : DRAIN);
                end
            endcase
        end
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            Phase <= START;
            Out <= PHASES'(1) << START_PHASE;
            CycleDone <= 1'b0;
            Busy <= 1'b0;
            stepQ <= 1'b0;
        end else begin
            state <= stateNext;
            Phase <= phaseNext;
            Out <= PHASES'(1) << phaseNext;
            CycleDone <= adv && wrap;
            Busy <= stateNext != IDLE;
            stepQ <= Step;
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for 16- and 10-phase sequencers driven by shared stimulus.
module tb_phase_sequencer;
    logic Clk, Rst, Run, Step, Hold, Dir, Load;
    logic [3:0] LoadPhase, phase16, phase10;
    logic [15:0] out16;
    logic [9:0] out10;
    logic cd16, cd10, busy16, busy10;
    int tests = 0, failed = 0;

    typedef struct {int phase; bit cd; bit busy;} exp_t;
    exp_t q16[$], q10[$];
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
    int mPhase[2], mMode[2];
    bit mStepQ[2];

    phase_sequencer #(.PHASES(16), .START_PHASE(0)) dut16 (
        .Clk(Clk), .Rst(Rst), .Run(Run), .Step(Step), .Hold(Hold), .Dir(Dir), .Load(Load),
        .LoadPhase(LoadPhase), .Out(out16), .Phase(phase16), .CycleDone(cd16), .Busy(busy16));
    phase_sequencer #(.PHASES(10), .START_PHASE(0)) dut10 (
        .Clk(Clk), .Rst(Rst), .Run(Run), .Step(Step), .Hold(Hold), .Dir(Dir), .Load(Load),
        .LoadPhase(LoadPhase), .Out(out10), .Phase(phase10), .CycleDone(cd10), .Busy(busy10));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mPhase[k] = 0;
            mMode[k] = M_IDLE;
            mStepQ[k] = 1'b0;
        end
        q16.delete();
        q10.delete();
    endtask

    task automatic modelStep(input int k, input int n);
        bit stepRise, loadOk, adv;
        int nxt;
        exp_t e;
        stepRise = Step && !mStepQ[k];
        loadOk = Load && int'(LoadPhase) < n;
        adv = 1'b0;
        nxt = Dir ? (mPhase[k] + n - 1) % n : (mPhase[k] + 1) % n;
        mStepQ[k] = Step;
        if (loadOk) begin
            if (mMode[k] == M_DRAIN && LoadPhase == 0) mMode[k] = M_IDLE;
        end else if (mMode[k] == M_IDLE) begin
            if (Run) mMode[k] = M_RUN;
            else adv = stepRise && !Hold;
        end else if (mMode[k] == M_RUN) begin
            if (!Run && mPhase[k] == 0) mMode[k] = M_IDLE;
            else begin
                adv = !Hold;
                if (!Run) mMode[k] = M_DRAIN;
            end
        end else begin
            adv = !Hold;
            if (Run) mMode[k] = M_RUN;
            else if (adv && nxt == 0) mMode[k] = M_IDLE;
        end
        e.cd = adv && (Dir ? mPhase[k] == 0 : mPhase[k] == n - 1);
        if (loadOk) mPhase[k] = int'(LoadPhase);
        else if (adv) mPhase[k] = nxt;
        e.phase = mPhase[k];
        e.busy = mMode[k] != M_IDLE;
        if (k == 0) q16.push_back(e);
        else q10.push_back(e);
    endtask

    task automatic cmp(input string nm, input bit have, input exp_t e, input int ph, input int oh,
                       input bit cd, input bit bz);
        tests++;
        if (!have) begin
            failed++;
            $display("FAIL %s: DUT output with no expected entry at %0t", nm, $time);
        end else if (ph != e.phase || oh != (1 << e.phase) || cd != e.cd || bz != e.busy) begin
            failed++;
            $display("FAIL %s at %0t: got phase=%0d out=%h cd=%b busy=%b, expected phase=%0d out=%h cd=%b busy=%b",
                     nm, $time, ph, oh, cd, bz, e.phase, 1 << e.phase, e.cd, e.busy);
        end
    endtask

    task automatic chkReset(input string nm);
        exp_t z;
        z = '{phase: 0, cd: 1'b0, busy: 1'b0};
        cmp({nm, "_16"}, 1'b1, z, int'(phase16), int'(out16), cd16, busy16);
        cmp({nm, "_10"}, 1'b1, z, int'(phase10), int'(out10), cd10, busy10);
    endtask

    initial forever begin
        @(posedge Clk);
        if (Rst) begin
            modelStep(0, 16);
            modelStep(1, 10);
        end
    end

    initial forever begin
        exp_t e;
        bit have;
        @(posedge Clk);
        #1;
        if (Rst) begin
            have = q16.size() > 0;
            if (have) e = q16.pop_front();
            cmp("seq16", have, e, int'(phase16), int'(out16), cd16, busy16);
            have = q10.size() > 0;
            if (have) e = q10.pop_front();
            cmp("seq10", have, e, int'(phase10), int'(out10), cd10, busy10);
        end
    end

    task automatic cyc(input bit r, input bit s, input bit h, input bit d, input bit l, input logic [3:0] lp);
        Run = r; Step = s; Hold = h; Dir = d; Load = l; LoadPhase = lp;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        bit r, d;
        Rst = 1'b0; Run = 0; Step = 0; Hold = 0; Dir = 0; Load = 0; LoadPhase = '0;
        resetModel();
        #12;
        chkReset("reset");
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #2;
        repeat (22) cyc(1, 0, 0, 0, 0, 0);
        repeat (14) cyc(0, 0, 0, 0, 0, 0);
        for (int h = 0; h < 2; h++)
            repeat (3) begin
                repeat (5) cyc(0, 1, h[0], 0, 0, 0);
                cyc(0, 0, h[0], 0, 0, 0);
            end
        cyc(0, 0, 0, 0, 1, 0);
        repeat (4) cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 1, 4'd7);
        cyc(1, 0, 0, 1, 1, 4'd12);
        repeat (3) cyc(1, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        r = 1'b0;
        d = 1'b0;
        repeat (1500) begin
            if ($urandom_range(7) == 0) r = !r;
            if ($urandom_range(9) == 0) d = !d;
            cyc(r, $urandom_range(1) == 1, $urandom_range(5) == 0, d, $urandom_range(11) == 0,
                4'($urandom_range(15)));
        end
        repeat (2) cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 4'd9);
        repeat (12) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4'd9);
        #1 Rst = 1'b0;
        #1 chkReset("midrun_reset");
        resetModel();
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #2;
        repeat (6) cyc(1, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
